lisp_obj_fetch: RTL and testbench
=================================

// Module: lisp_obj_fetch
// PURPOSE
//  Object-fetch stage between the evaluator FSM (SelectExpr/MemWait/Eval) and the 4K x 8 heap RAM.
//  Accepts an object address from the evaluator and reads the header byte at A and the value byte at A+1.
//  Checks the header against header_t and returns {header, value, err_code} on a valid/ready response.
//  The evaluator parks in MemWait while this block is busy.
// PARAMETERS
//  ADDR_WIDTH  12  heap address width (lisp::addr_width)
//  DATA_WIDTH  8   heap word width (lisp::data_width)
// PORTS
//  clk          in   1           system clock, rising edge
//  rst_n        in   1           asynchronous reset, active low
//  req_valid    in   1           evaluator presents fetch request
//  req_ready    out  1           block can accept request (IDLE only)
//  req_addr     in   ADDR_WIDTH  object base address A
//  rsp_valid    out  1           response available
//  rsp_ready    in   1           evaluator consumes response
//  rsp_header   out  DATA_WIDTH  header byte read at A
//  rsp_value    out  DATA_WIDTH  value byte read at A+1 (0 on error)
//  rsp_err      out  2           0=OK, 1=unknown header, 2=address out of range
//  mem_addr     out  ADDR_WIDTH  heap read address (registered)
//  mem_rd_en    out  1           heap read strobe (registered)
//  mem_rdata    in   DATA_WIDTH  heap read data, valid the cycle after mem_rd_en is high
// BEHAVIOUR
//  - Clock/reset: one clock, clk. rst_n is asynchronous, active low. Reset forces state=IDLE and all
//    outputs to 0 except req_ready, which is 1 (combinational from IDLE). Reset mid-operation abandons
//    the fetch with no response.
//  - Handshakes: a request is taken on an edge with req_valid&&req_ready. A response is retired on an
//    edge with rsp_valid&&rsp_ready.
//  - rsp_* hold stable while rsp_valid && !rsp_ready. At most one fetch is in flight.
//  - FSM: IDLE -> RD_HDR -> HDR_WAIT -> RD_VAL -> VAL_WAIT -> RESP -> IDLE.
//  - IDLE: req_ready=1. On a request:
//      - A == 2^ADDR_WIDTH-1 (the value byte would overflow the heap): set rsp_err=2, rsp_header=0,
//        rsp_value=0, go to RESP. No memory read is issued.
//      - Otherwise: mem_addr<=A, mem_rd_en<=1, latch A, go to RD_HDR.
//  - RD_HDR: mem_rd_en<=0, go to HDR_WAIT.
//  - HDR_WAIT: rsp_header<=mem_rdata.
//      - If mem_rdata is a header_t member (TYPE_NUMBER=8'h00): mem_addr<=A+1, mem_rd_en<=1, go to RD_VAL.
//      - Else: rsp_err<=1, rsp_value<=0, go to RESP.
//  - RD_VAL: mem_rd_en<=0, go to VAL_WAIT.
//  - VAL_WAIT: rsp_value<=mem_rdata, rsp_err<=0, go to RESP.
//  - RESP: rsp_valid=1. On rsp_ready, go to IDLE; rsp_valid drops and req_ready rises in the next cycle.
//    Responses are never back-to-back.
//  - Latency (request edge = edge 0): rsp_valid high from cycle 5 (OK), cycle 3 (err=1), cycle 1 (err=2).
//  - mem_rd_en is high for exactly 1 cycle per byte read: 2 pulses for an OK fetch, 1 for err=1, 0 for err=2.
//  - The address is latched at acceptance, so req_addr changes after the handshake are ignored.
//  - req_valid while busy is not accepted (req_ready=0) and must be held by the evaluator.
//  - rsp_ready asserted before rsp_valid has no effect.
// TESTING
//  - Reset: rst_n=0 mid-fetch (state VAL_WAIT) -> next cycle req_ready=1, rsp_valid=0, mem_rd_en=0;
//    no stale response appears afterwards.
//  - OK fetch: heap[0x010]=8'h00, heap[0x011]=8'h2A, req A=0x010, rsp_ready=1 -> mem_rd_en pulses at
//    0x010 and 0x011; rsp_valid at cycle 5 with header=00, value=2A, err=0.
//  - Bad header: heap[0x100]=8'h07, req A=0x100 -> rsp_valid at cycle 3 with header=07, value=00, err=1;
//    exactly one mem_rd_en pulse.
//  - Top of heap: req A=0xFFF -> rsp_valid at cycle 1, err=2, no mem_rd_en pulse.
//  - Backpressure: OK fetch with rsp_ready=0 for 4 cycles -> rsp_* stable and req_ready=0 throughout;
//    retire on rsp_ready=1; req_ready=1 the following cycle.
//  - Busy request: second req_valid asserted at cycle 2 with A=0x020 -> not accepted until after the
//    first response retires; then fetches 0x020/0x021 correctly.

Source files
------------

// File: rtl/lisp_obj_fetch.sv
// Object-fetch stage: reads the header byte at A and the value byte at A+1 from the heap RAM,
// validates the header and hands {header, value, err} back to the evaluator over valid/ready.
module lisp_obj_fetch #(
  parameter int ADDR_WIDTH = 12,
  parameter int DATA_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [DATA_WIDTH-1:0] rsp_header,
  output logic [DATA_WIDTH-1:0] rsp_value,
  output logic [1:0]            rsp_err,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic                  mem_rd_en,
  input  logic [DATA_WIDTH-1:0] mem_rdata
);

  typedef enum logic [2:0] {
    IDLE,
    RD_HDR,
    HDR_WAIT,
    RD_VAL,
    VAL_WAIT,
    RESP
  } state_t;

  typedef enum logic [7:0] {
    TYPE_NUMBER = 8'h00
  } header_t;

  localparam logic [1:0] ERR_OK    = 2'd0;
  localparam logic [1:0] ERR_HDR   = 2'd1;
  localparam logic [1:0] ERR_RANGE = 2'd2;

  // An object at the last heap word has no room for its value byte.
  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = '1;

  function automatic logic known_header(input logic [DATA_WIDTH-1:0] b);
    return (b == DATA_WIDTH'(TYPE_NUMBER));
  endfunction

  state_t                state, state_n;
  logic [ADDR_WIDTH-1:0] obj_addr, obj_addr_n;
  logic [ADDR_WIDTH-1:0] mem_addr_n;
  logic                  mem_rd_en_n;
  logic [DATA_WIDTH-1:0] header_n;
  logic [DATA_WIDTH-1:0] value_n;
  logic [1:0]            err_n;

  assign req_ready = (state == IDLE);
  assign rsp_valid = (state == RESP);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      obj_addr   <= '0;
      mem_addr   <= '0;
      mem_rd_en  <= 1'b0;
      rsp_header <= '0;
      rsp_value  <= '0;
      rsp_err    <= ERR_OK;
    end else begin
      state      <= state_n;
      obj_addr   <= obj_addr_n;
      mem_addr   <= mem_addr_n;
      mem_rd_en  <= mem_rd_en_n;
      rsp_header <= header_n;
      rsp_value  <= value_n;
      rsp_err    <= err_n;
    end
  end

  // Response fields only change on the way into RESP, so they hold while the evaluator stalls.
  always_comb begin
    state_n     = state;
    obj_addr_n  = obj_addr;
    mem_addr_n  = mem_addr;
    mem_rd_en_n = 1'b0;
    header_n    = rsp_header;
    value_n     = rsp_value;
    err_n       = rsp_err;

    case (state)
      IDLE: begin
        if (req_valid) begin
          if (req_addr == LAST_ADDR) begin
            header_n = '0;
            value_n  = '0;
            err_n    = ERR_RANGE;
            state_n  = RESP;
          end else begin
            obj_addr_n  = req_addr;
            mem_addr_n  = req_addr;
            mem_rd_en_n = 1'b1;
            state_n     = RD_HDR;
          end
        end
      end
      RD_HDR: state_n = HDR_WAIT;
      HDR_WAIT: begin
        header_n = mem_rdata;
        if (known_header(mem_rdata)) begin
          mem_addr_n  = obj_addr + ADDR_WIDTH'(1);
          mem_rd_en_n = 1'b1;
          state_n     = RD_VAL;
        end else begin
          value_n = '0;
          err_n   = ERR_HDR;
          state_n = RESP;
        end
      end
      RD_VAL: state_n = VAL_WAIT;
      VAL_WAIT: begin
        value_n = mem_rdata;
        err_n   = ERR_OK;
        state_n = RESP;
      end
      RESP: begin
        if (rsp_ready) state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

endmodule

// File: tb/tb_lisp_obj_fetch.sv
// Randomised self-checking bench for lisp_obj_fetch against a heap model and a
// fetch-level reference computed from the object layout rules.
module tb_lisp_obj_fetch;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_valid;
  logic        req_ready;
  logic [11:0] req_addr;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [7:0]  rsp_header;
  logic [7:0]  rsp_value;
  logic [1:0]  rsp_err;
  logic [11:0] mem_addr;
  logic        mem_rd_en;
  logic [7:0]  mem_rdata;

  logic [7:0]  heap [0:4095];
  int          checkCount = 0;
  int          failCount = 0;

  always #5 clk = ~clk;

  lisp_obj_fetch #(.ADDR_WIDTH(12), .DATA_WIDTH(8)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_addr  (req_addr),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_header(rsp_header),
    .rsp_value (rsp_value),
    .rsp_err   (rsp_err),
    .mem_addr  (mem_addr),
    .mem_rd_en (mem_rd_en),
    .mem_rdata (mem_rdata)
  );

  // Synchronous-read heap RAM: data appears the cycle after the strobe.
  always @(posedge clk) begin
    if (mem_rd_en) mem_rdata <= heap[mem_addr];
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checkCount++;
    if (observed !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
    end
  endtask

  // One complete fetch: request, latency/pulse tracking, optional backpressure, retire.
  task automatic applyStimulus(input logic [11:0] addr, input int stall,
                               input bit holdNext, input logic [11:0] nextAddr);
    logic [7:0]  eHdr;
    logic [7:0]  eVal;
    logic [1:0]  eErr;
    int          eLat;
    int          ePulses;
    int          cycle;
    int          pulses;
    int          budget;
    logic [11:0] pulseAddr[$];

    if (addr == 12'hFFF) begin
      eHdr = 8'h00; eVal = 8'h00; eErr = 2'd2; eLat = 1; ePulses = 0;
    end else if (heap[addr] != 8'h00) begin
      eHdr = heap[addr]; eVal = 8'h00; eErr = 2'd1; eLat = 3; ePulses = 1;
    end else begin
      eHdr = 8'h00; eVal = heap[addr + 12'd1]; eErr = 2'd0; eLat = 5; ePulses = 2;
    end

    rsp_ready = (stall == 0);
    req_valid = 1'b1;
    req_addr  = addr;
    budget = 0;
    while (!req_ready && budget < 30) begin
      @(negedge clk);
      budget++;
    end
    checkOutput("accept_in_time", 32'(budget < 30), 32'd1);
    @(posedge clk);
    @(negedge clk);
    cycle = 1;
    req_valid = 1'b0;
    req_addr  = 12'($urandom);
    pulses = 0;
    forever begin
      if (mem_rd_en) begin
        pulses++;
        pulseAddr.push_back(mem_addr);
      end
      if (rsp_valid || cycle >= 20) break;
      checkOutput("busy_req_ready", 32'(req_ready), 32'd0);
      @(negedge clk);
      cycle++;
      if (holdNext && cycle == 2) begin
        req_valid = 1'b1;
        req_addr  = nextAddr;
      end
    end

    checkOutput("rsp_latency", 32'(cycle), 32'(eLat));
    checkOutput("rsp_header", 32'(rsp_header), 32'(eHdr));
    checkOutput("rsp_value", 32'(rsp_value), 32'(eVal));
    checkOutput("rsp_err", 32'(rsp_err), 32'(eErr));
    checkOutput("rd_pulses", 32'(pulses), 32'(ePulses));
    for (int i = 0; i < pulseAddr.size() && i < ePulses; i++)
      checkOutput("rd_addr", 32'(pulseAddr[i]), 32'(addr + 12'(i)));

    for (int s = 0; s < stall; s++) begin
      @(negedge clk);
      checkOutput("stall_valid", 32'(rsp_valid), 32'd1);
      checkOutput("stall_req_ready", 32'(req_ready), 32'd0);
      checkOutput("stall_fields", {14'd0, rsp_header, rsp_value, rsp_err}, {14'd0, eHdr, eVal, eErr});
      checkOutput("stall_rd_en", 32'(mem_rd_en), 32'd0);
    end
    rsp_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    checkOutput("retire_valid", 32'(rsp_valid), 32'd0);
    checkOutput("retire_req_ready", 32'(req_ready), 32'd1);
    checkOutput("retire_rd_en", 32'(mem_rd_en), 32'd0);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout, expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [11:0] a;

    for (int i = 0; i < 4096; i++)
      heap[i] = ($urandom_range(0, 1) == 1) ? 8'h00 : 8'($urandom);
    heap[12'h010] = 8'h00;
    heap[12'h011] = 8'h2A;
    heap[12'h100] = 8'h07;
    heap[12'h020] = 8'h00;
    heap[12'h021] = 8'h5C;

    rst_n = 1'b0; req_valid = 1'b0; rsp_ready = 1'b0; req_addr = '0;
    #12;
    checkOutput("reset_req_ready", 32'(req_ready), 32'd1);
    checkOutput("reset_rsp_valid", 32'(rsp_valid), 32'd0);
    checkOutput("reset_rd_en", 32'(mem_rd_en), 32'd0);
    checkOutput("reset_outputs", {10'd0, mem_addr, rsp_header, rsp_err}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    applyStimulus(12'h010, 0, 1'b0, 12'h000);
    applyStimulus(12'h100, 0, 1'b0, 12'h000);
    applyStimulus(12'hFFF, 0, 1'b0, 12'h000);
    applyStimulus(12'h010, 4, 1'b0, 12'h000);
    applyStimulus(12'h010, 0, 1'b1, 12'h020);
    applyStimulus(12'h020, 1, 1'b0, 12'h000);

    // Reset while the value byte is outstanding must drop the fetch entirely.
    req_valid = 1'b1; req_addr = 12'h010; rsp_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    checkOutput("midreset_req_ready", 32'(req_ready), 32'd1);
    checkOutput("midreset_rsp_valid", 32'(rsp_valid), 32'd0);
    checkOutput("midreset_rd_en", 32'(mem_rd_en), 32'd0);
    rst_n = 1'b1;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      checkOutput("no_stale_rsp", {30'd0, rsp_valid, mem_rd_en}, 32'd0);
    end

    for (int n = 0; n < 40; n++) begin
      a = ($urandom_range(0, 7) == 0) ? 12'hFFF : 12'($urandom);
      applyStimulus(a, $urandom_range(0, 3), 1'b0, 12'h000);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", checkCount, failCount);
    $finish;
  end

endmodule
